// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // True for the two divide opcodes.
  function automatic logic op_is_div(input op_e o);
    return (o == DIV) || (o == DIVU);
  endfunction

  // True for the two signed opcodes.
  function automatic logic op_is_signed(input op_e o);
    return (o == MULT) || (o == DIV);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
// step_quo/step_rem show the result of applying one more step to the current
// state, so the owner can consume the final step without an extra cycle.
module div_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] step_quo,
  output logic [WIDTH-1:0] step_rem
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign step_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  // Working registers: quotient shifts in from the right as the dividend shifts out.
  // NOTE: datapath registers are reset too; it costs little and keeps X out of simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= step_quo;
      rem_q <= step_rem;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO multiply/divide unit.
// Iterative: WIDTH cycles per multiply or divide, sign fix-up in FINISH.
// Optional macro MDU_FAST_MUL_EN: multiplies use a single-cycle array product.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e state, state_nx;
  logic   accept, do_step, do_finish;

  // Decoded request
  op_e              op_in;
  logic             in_div, in_signed, in_fast;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Captured operation context
  logic             div_q;
  logic             neg_p;   // sign of product / quotient
  logic             neg_r;   // sign of remainder
  logic             b_zero;
  logic [WIDTH-1:0] a_q;
  logic [CW-1:0]    cnt;

  // Multiply datapath: {mul_hi, mul_lo} holds partial product and remaining multiplier
  logic [WIDTH-1:0]   mcand, mul_hi, mul_lo;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_mag, prod;

  // Divider results and final values
  logic [WIDTH-1:0] step_quo, step_rem, quo_fix, rem_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_in     = op_e'(op);
  assign in_div    = op_is_div(op_in);
  assign in_signed = op_is_signed(op_in);
  assign mag_a     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (in_signed && b[WIDTH-1]) ? -b : b;

`ifdef MDU_FAST_MUL_EN
  assign in_fast = !in_div;
`else
  assign in_fast = 1'b0;
`endif

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and per-cycle control strobes; flush always wins.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nx  = state;
    accept    = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          accept   = 1'b1;
          state_nx = (in_fast || (in_div && b == '0)) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_nx = IDLE;
        end else begin
          do_step = 1'b1;
          if (cnt == CW'(WIDTH - 2)) state_nx = FINISH;
        end
      end
      FINISH: begin
        state_nx = IDLE;
        if (!flush) do_finish = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && in_div),
    .step     (do_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .step_quo (step_quo),
    .step_rem (step_rem)
  );

  // One shift-add step: add multiplicand when the current multiplier bit is set.
  assign mul_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : '0);

`ifdef MDU_FAST_MUL_EN
  assign prod_mag = {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, mul_lo};
`else
  // Final step applied combinationally in FINISH.
  assign prod_mag = {mul_sum, mul_lo[WIDTH-1:1]};
`endif

  assign prod    = neg_p ? -prod_mag : prod_mag;
  assign quo_fix = neg_p ? -step_quo : step_quo;
  assign rem_fix = neg_r ? -step_rem : step_rem;
  assign res_hi  = !div_q ? prod[2*WIDTH-1:WIDTH] : (b_zero ? a_q : rem_fix);
  assign res_lo  = !div_q ? prod[WIDTH-1:0]       : (b_zero ? '1  : quo_fix);

  // Operand capture on acceptance and multiply iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 1'b0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_q    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mul_hi <= '0;
      mul_lo <= '0;
    end else if (accept) begin
      div_q  <= in_div;
      neg_p  <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= in_signed && a[WIDTH-1];
      b_zero <= (b == '0);
      a_q    <= a;
      cnt    <= '0;
      mcand  <= mag_a;
      mul_hi <= '0;
      mul_lo <= mag_b;
    end else if (do_step) begin
      cnt              <= cnt + CW'(1);
      {mul_hi, mul_lo} <= {mul_sum, mul_lo[WIDTH-1:1]};
    end
  end

  // HI/LO: result write in FINISH, direct MTHI/MTLO writes only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= do_finish;
      if (do_finish) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): directed table, corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] av, bv, eh, el,
                              input string nm);
    vec_t v;
    v.op = o; v.a = av; v.b = bv; v.exp_hi = eh; v.exp_lo = el; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] av, bv);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    case (o)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      default: begin
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          q = sa / sb;
          r = sa - q * sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Edges from acceptance to done.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] bv);
    if (o[1] && bv == 32'd0) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!o[1]) return 1;
`endif
    return W;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let one edge accept it, then scramble a/b.
  task automatic launch(input logic [1:0] o, input logic [31:0] av, bv);
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  // Wait (bounded) for done, then check latency, result and single pulse semantics.
  task automatic wait_done(input string nm, input logic [31:0] eh, el,
                           input int lat, input int elapsed);
    int n;
    bit seen;
    n = elapsed;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    check({nm, "_latency"}, seen ? 64'(n) : 64'hDEAD, 64'(lat));
    check({nm, "_hi"}, {32'd0, hi}, {32'd0, eh});
    check({nm, "_lo"}, {32'd0, lo}, {32'd0, el});
    check({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          dones;

    vecs[0]  = mk(2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
    vecs[1]  = mk(2'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, "multu_max_x2");
    vecs[2]  = mk(2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    vecs[3]  = mk(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, "div_min_m1");
    vecs[4]  = mk(2'd3, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, "divu_by0");
    vecs[5]  = mk(2'd3, 32'd100,       32'd7,        32'd2,         32'd14,        "divu_100_7");
    vecs[6]  = mk(2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, "div_7_m2");
    vecs[7]  = mk(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        "mult_min_min");
    vecs[8]  = mk(2'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_m7_by0");
    vecs[9]  = mk(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'h1,         "mult_m1_m1");
    vecs[10] = mk(2'd3, 32'hFFFF_FFFF, 32'd1,        32'h0,         32'hFFFF_FFFF, "divu_max_1");

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; a = '0; b = '0; wdata = '0;

    // Reset state
    repeat (3) tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);

    // Directed table, first start right after reset release, all back-to-back
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo,
                exp_lat(vecs[i].op, vecs[i].b), 0);
    end
    tick();
    check("done_single_pulse", {63'd0, done}, 64'd0);

    // Direct HI/LO writes while idle
    hi_we = 1'b1; wdata = 32'hA5A5_1234;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_5678;
    tick();
    lo_we = 1'b0;
    check("mthi_idle", {32'd0, hi}, 64'hA5A5_1234);
    check("mtlo_idle", {32'd0, lo}, 64'h5A5A_5678);

    // start and hi_we/lo_we while busy are ignored
    launch(2'd3, 32'd1000, 32'd3);
    repeat (2) tick();
    start = 1'b1; op = 2'd3; a = 32'd5; b = 32'd0;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("busy_write_hi", {32'd0, hi}, 64'hA5A5_1234);
    check("busy_write_lo", {32'd0, lo}, 64'h5A5A_5678);
    wait_done("divu_busy_ignore", 32'd1, 32'd333, W, 3);

    // flush beats a simultaneous start in IDLE
    tick();
    start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_over_start", {63'd0, busy}, 64'd0);

    // Flush at cycle 10 of DIVU 100/7, restart one cycle later
    launch(2'd3, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_hi_kept", {32'd0, hi}, 64'd1);
    check("flush_lo_kept", {32'd0, lo}, 64'd333);
    tick();
    launch(2'd3, 32'd100, 32'd7);
    wait_done("divu_after_flush", 32'd2, 32'd14, W, 0);

    // Asynchronous reset in the middle of a multiply
    launch(2'd0, 32'd3, 32'd4);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midop_reset_hi", {32'd0, hi}, 64'd0);
    check("midop_reset_lo", {32'd0, lo}, 64'd0);
    check("midop_reset_busy", {63'd0, busy}, 64'd0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    check("no_done_after_reset", 64'(dones), 64'd0);

    // Randomized back-to-back operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      r = model(ro, ra, rb);
      launch(ro, ra, rb);
      wait_done($sformatf("rand%0d_op%0d", i, ro), r[63:32], r[31:0], exp_lat(ro, rb), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width; legal values are even integers of 8 or more.
REQ-002 Port: clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 Port: rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 Port: start, input, 1, request to begin the operation in op.
REQ-005 Port: op, input, 2, operation code: MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-006 Port: a, input, WIDTH, multiplicand or dividend.
REQ-007 Port: b, input, WIDTH, multiplier or divisor.
REQ-008 Port: flush, input, 1, abort any in-flight operation.
REQ-009 Port: hi_we, input, 1, direct write of HI (MTHI).
REQ-010 Port: lo_we, input, 1, direct write of LO (MTLO).
REQ-011 Port: wdata, input, WIDTH, data for hi_we/lo_we.
REQ-012 Port: busy, output, 1, an operation is in flight.
REQ-013 Port: done, output, 1, one-cycle pulse on the cycle HI/LO hold a new result.
REQ-014 Port: hi, output, WIDTH, HI register (MFHI); upper product or remainder.
REQ-015 Port: lo, output, WIDTH, LO register (MFLO); lower product or quotient.

Function
REQ-016 FSM states SHALL be IDLE, RUN, FINISH; busy=1 exactly in RUN and FINISH.
REQ-017 start SHALL be accepted only in IDLE with flush=0; a and b are captured on the accepting edge and later changes are ignored.
REQ-018 start while busy SHALL be ignored and SHALL NOT disturb the in-flight operation.
REQ-019 Iterative mode: radix-2 shift-add multiply and restoring divide, one bit per cycle; HI/LO update and done=1 SHALL occur at the WIDTH-th rising edge after the accepting edge.
REQ-020 Signed ops SHALL operate on magnitudes and correct signs at FINISH: product sign = a^b; quotient sign = a^b; remainder sign = sign of a.
REQ-021 MULT/MULTU: {hi,lo} SHALL equal the full 2*WIDTH-bit signed/unsigned product.
REQ-022 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder, with a == q*b + r.
REQ-023 DIV of most-negative by -1 SHALL give lo = most-negative and hi = 0, with no exception.
REQ-024 Divide by zero SHALL finish at the 1st edge after acceptance with hi = a and lo = all ones.
REQ-025 flush=1 SHALL return the FSM to IDLE on the next edge with HI/LO unchanged and no done pulse; flush wins over a simultaneous start.
REQ-026 hi_we/lo_we SHALL update HI/LO only in IDLE; while busy they are ignored.
REQ-027 done and a hi_we/lo_we write in the same cycle SHALL be impossible because of REQ-026; back-to-back start on the cycle done=1 SHALL be accepted.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE with busy=0, done=0, hi=0, lo=0 and discard any in-flight operation.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro MDU_FAST_MUL_EN defined: MULT/MULTU SHALL use a single-cycle array product finishing at the 1st edge after acceptance; divides remain iterative.
REQ-031 Macro MDU_FAST_MUL_EN undefined: all multiplies SHALL be iterative per REQ-019.

Structure
REQ-032 Package mdu_pkg SHALL hold the op enum (MULT/MULTU/DIV/DIVU), the FSM state enum and the default WIDTH constant.
REQ-033 The iterative restoring divide datapath SHALL be a sub-module named div_iter; the multiply stays inline.

Verification (WIDTH=32)
REQ-034 MULT a=-3, b=5 -> after 32 edges, hi=0xFFFFFFFF, lo=0xFFFFFFF1, and done pulses once.
REQ-035 MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; with MDU_FAST_MUL_EN, done 1 edge after acceptance.
REQ-036 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-037 DIVU a=7, b=0 -> 1 edge later hi=7, lo=0xFFFFFFFF, done=1.
REQ-038 Start DIVU 100/7, flush at cycle 10 -> busy=0 next cycle, HI/LO keep prior values, no done; a new start 1 cycle later completes with lo=14, hi=2.
REQ-039 rst_n=0 at cycle 5 of MULT -> hi=lo=0 and busy=0 immediately; start during busy and hi_we during busy -> no effect.
